// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // First fetch address after reset unless the instance overrides it.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction buffer entries; the buffer hardware is built for exactly two.
  localparam int FETCH_DEPTH = 2;

  // Fetch sequencer states.
  //   ST_IDLE  : one cycle after reset, no request
  //   ST_FETCH : request presented when the buffer has room
  //   ST_WAIT  : request held until the memory returns the word
  //   ST_DROP  : a redirect orphaned the in-flight request; its response is discarded
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  // One buffered instruction and the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer with a registered head.
// The head entry and its pc+4 link value come straight from flops so decode
// sees a clean, stable word. Flush wins over push and pop in the same cycle;
// push and pop together on a full buffer both take effect.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic         head_valid,
  output fetch_entry_t head_entry,
  output logic [31:0]  head_pc4,
  output logic [1:0]   count
);

  fetch_entry_t head_q;
  fetch_entry_t tail_q;
  logic [31:0]  head_pc4_q;
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // Buffer storage and occupancy; entries shift toward the head on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_pc4_q <= '0;
      count_q    <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q     <= push_entry;
            head_pc4_q <= push_entry.pc + 32'd4;
          end else begin
            head_q     <= tail_q;
            head_pc4_q <= tail_q.pc + 32'd4;
            tail_q     <= push_entry;
          end
        end
        2'b01: begin
          head_q     <= tail_q;
          head_pc4_q <= tail_q.pc + 32'd4;
          count_q    <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q     <= push_entry;
            head_pc4_q <= push_entry.pc + 32'd4;
          end else begin
            tail_q <= push_entry;
          end
          count_q <= count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_entry = head_q;
  assign head_pc4   = head_pc4_q;
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, one outstanding memory request,
// two-entry instruction buffer toward decode, redirect with flush.
//
// Handshakes:
//   imem_req/imem_rvalid : at most one request in flight. imem_req and
//     imem_addr stay constant from the first request cycle until the cycle
//     imem_rvalid is seen (inclusive). After a redirect the orphaned request
//     is tracked internally (ST_DROP) with imem_req low, and its single
//     response is discarded.
//   instr_valid/instr_ready : the head moves when both are high on a rising
//     edge; while instr_valid && !instr_ready the head is held unchanged.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic [31:0]  instr_pc4,
  output fetch_state_e state_dbg
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  fetch_pc_d;
  logic [1:0]   buf_count;
  logic         outstanding;
  logic [2:0]   in_flight;
  logic         room;
  logic         push;
  logic         pop;
  logic         flush;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // A request counts against the buffer from issue until its response.
  assign outstanding = (state_q == ST_WAIT) || (state_q == ST_DROP);
  assign in_flight   = {1'b0, buf_count} + {2'b00, outstanding};
  assign room        = (in_flight < 3'(DEPTH));

  // State and fetch address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next state, next fetch address, memory request and buffer controls.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = word_align(redirect_pc);
        end
      end
      ST_FETCH: begin
        imem_req = room;
        if (redirect) begin
          // A request presented this cycle is already with the memory.
          flush      = 1'b1;
          fetch_pc_d = word_align(redirect_pc);
          state_d    = room ? ST_DROP : ST_FETCH;
        end else if (room) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = word_align(redirect_pc);
          // A word returning with the redirect belongs to the old path.
          state_d    = imem_rvalid ? ST_FETCH : ST_DROP;
        end else if (imem_rvalid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_FETCH;
        end
      end
      ST_DROP: begin
        // The buffer is already empty; only the newest target matters.
        if (redirect) begin
          fetch_pc_d = word_align(redirect_pc);
        end
        if (imem_rvalid) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign push_entry = '{pc: fetch_pc_q, instr: imem_rdata};
  assign pop        = instr_valid && instr_ready;
  assign imem_addr  = fetch_pc_q;
  assign state_dbg  = state_q;

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_valid (instr_valid),
    .head_entry (head_entry),
    .head_pc4   (instr_pc4),
    .count      (buf_count)
  );

  assign instr    = head_entry.instr;
  assign instr_pc = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a default-reset instance (dut0) driven by
// a variable-latency memory model, and a second instance reset near the top
// of the address space (dut1) with a single-cycle memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset / shared inputs ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  // dut0 signals
  logic         d0_imem_req;
  logic [31:0]  d0_imem_addr;
  logic         d0_imem_rvalid = 1'b0;
  logic [31:0]  d0_imem_rdata = 32'h0;
  logic         d0_instr_valid;
  logic [31:0]  d0_instr, d0_instr_pc, d0_instr_pc4;
  fetch_state_e d0_state;

  // dut1 signals
  logic         d1_imem_req;
  logic [31:0]  d1_imem_addr;
  logic         d1_imem_rvalid = 1'b0;
  logic [31:0]  d1_imem_rdata = 32'h0;
  logic         d1_instr_valid;
  logic [31:0]  d1_instr, d1_instr_pc, d1_instr_pc4;
  fetch_state_e d1_state;

  int tests_run = 0;
  int tests_failed = 0;

  // memory model controls and logs
  int          mem_lat = 1;
  bit          mem_en = 1'b1;
  bit          d0_busy = 1'b0;
  int          d0_cnt = 0;
  logic [31:0] d0_addr_q = 32'h0;
  bit          d1_busy = 1'b0;
  logic [31:0] d1_addr_q = 32'h0;
  logic [31:0] d0_req_log[$];
  logic [31:0] d1_req_log[$];

  // scoreboard: what decode actually consumed, and what it should consume
  logic [31:0] got_pc_q[$];
  logic [31:0] got_pc4_q[$];
  logic [31:0] got_instr_q[$];
  logic [31:0] w_pc_q[$];
  logic [31:0] w_pc4_q[$];
  logic [31:0] exp_q[$];

  fetch_unit dut0 (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (d0_imem_req),
    .imem_addr   (d0_imem_addr),
    .imem_rvalid (d0_imem_rvalid),
    .imem_rdata  (d0_imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (d0_instr_valid),
    .instr_ready (instr_ready),
    .instr       (d0_instr),
    .instr_pc    (d0_instr_pc),
    .instr_pc4   (d0_instr_pc4),
    .state_dbg   (d0_state)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (d1_imem_req),
    .imem_addr   (d1_imem_addr),
    .imem_rvalid (d1_imem_rvalid),
    .imem_rdata  (d1_imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (d1_instr_valid),
    .instr_ready (instr_ready),
    .instr       (d1_instr),
    .instr_pc    (d1_instr_pc),
    .instr_pc4   (d1_instr_pc4),
    .state_dbg   (d1_state)
  );

  // dut0 memory: accepts a request when idle, answers mem_lat cycles later
  // with the bitwise complement of the address as the instruction word.
  always @(negedge clk) begin
    if (rst) begin
      d0_busy = 1'b0;
      if (mem_en) d0_imem_rvalid = 1'b0;
    end else if (mem_en) begin
      d0_imem_rvalid = 1'b0;
      if (d0_busy) begin
        d0_cnt--;
        if (d0_cnt == 0) begin
          d0_imem_rvalid = 1'b1;
          d0_imem_rdata  = ~d0_addr_q;
          d0_busy        = 1'b0;
        end
      end else if (d0_imem_req) begin
        d0_busy   = 1'b1;
        d0_cnt    = mem_lat;
        d0_addr_q = d0_imem_addr;
        d0_req_log.push_back(d0_imem_addr);
      end
    end
  end

  // dut1 memory: fixed single-cycle latency.
  always @(negedge clk) begin
    if (rst) begin
      d1_busy        = 1'b0;
      d1_imem_rvalid = 1'b0;
    end else begin
      d1_imem_rvalid = 1'b0;
      if (d1_busy) begin
        d1_imem_rvalid = 1'b1;
        d1_imem_rdata  = ~d1_addr_q;
        d1_busy        = 1'b0;
      end else if (d1_imem_req) begin
        d1_busy   = 1'b1;
        d1_addr_q = d1_imem_addr;
        d1_req_log.push_back(d1_imem_addr);
      end
    end
  end

  // Decode-side monitor: records every head that is accepted.
  always begin
    @(negedge clk);
    #3;
    if (d0_instr_valid && instr_ready) begin
      got_pc_q.push_back(d0_instr_pc);
      got_pc4_q.push_back(d0_instr_pc4);
      got_instr_q.push_back(d0_instr);
    end
    if (d1_instr_valid && instr_ready) begin
      w_pc_q.push_back(d1_instr_pc);
      w_pc4_q.push_back(d1_instr_pc4);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    d0_req_log.delete();
    d1_req_log.delete();
    got_pc_q.delete();
    got_pc4_q.delete();
    got_instr_q.delete();
    w_pc_q.delete();
    w_pc4_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    mem_en   = 1'b1;
    tick();
    tick();
    clear_logs();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    tick();
    tests_run++;
    if (d0_imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0b expected 0", d0_imem_req); end
    tests_run++;
    if (d0_instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", d0_instr_valid); end
    tests_run++;
    if (d0_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h expected 0", d0_instr); end
    tests_run++;
    if (d0_instr_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_instr_pc: got %h expected 0", d0_instr_pc); end
    tests_run++;
    if (d0_instr_pc4 !== 32'h0) begin tests_failed++; $display("FAIL reset_instr_pc4: got %h expected 0", d0_instr_pc4); end
    tests_run++;
    if (d0_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", d0_state, ST_IDLE); end
    tests_run++;
    if (d1_imem_addr !== WRAP_PC) begin tests_failed++; $display("FAIL reset_pc_param: got %h expected %h", d1_imem_addr, WRAP_PC); end
    instr_ready = 1'b1;
    mem_lat     = 1;
    clear_logs();
    rst = 1'b0;
    #1;
    tests_run++;
    if (d0_state !== ST_IDLE || d0_imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL release_idle: got state %0d req %0b expected state %0d req 0", d0_state, d0_imem_req, ST_IDLE);
    end
    tick();
    tests_run++;
    if (d0_state !== ST_FETCH || d0_imem_req !== 1'b1 || d0_imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL first_fetch: got state %0d req %0b addr %h expected state %0d req 1 addr 0", d0_state, d0_imem_req, d0_imem_addr, ST_FETCH);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req[3];
    exp_req = '{32'h0, 32'h4, 32'h8};
    instr_ready = 1'b1;
    mem_lat     = 1;
    do_reset();
    repeat (30) tick();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    tests_run++;
    if (d0_req_log.size() < 3) begin
      tests_failed++; $display("FAIL stream_req_count: got %0d requests expected at least 3", d0_req_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (d0_req_log[i] !== exp_req[i]) begin tests_failed++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, d0_req_log[i], exp_req[i]); end
      end
    end
    tests_run++;
    if (got_pc_q.size() < 4) begin
      tests_failed++; $display("FAIL stream_pop_count: got %0d entries expected at least 4", got_pc_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_pc_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, got_pc_q[i], exp_q[i]); end
      end
      tests_run++;
      if (got_pc4_q[0] !== 32'h4) begin tests_failed++; $display("FAIL stream_pc4: got %h expected 00000004", got_pc4_q[0]); end
      tests_run++;
      if (got_instr_q[0] !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL stream_instr: got %h expected ffffffff", got_instr_q[0]); end
      tests_run++;
      if (got_instr_q[2] !== 32'hFFFF_FFF7) begin tests_failed++; $display("FAIL stream_instr2: got %h expected fffffff7", got_instr_q[2]); end
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    mem_lat     = 1;
    do_reset();
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (d0_imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req[%0d]: got %0b expected 0", i, d0_imem_req); end
      tests_run++;
      if (d0_instr_valid !== 1'b1 || d0_instr_pc !== 32'h0) begin
        tests_failed++; $display("FAIL stall_head[%0d]: got valid %0b pc %h expected valid 1 pc 0", i, d0_instr_valid, d0_instr_pc);
      end
      tests_run++;
      if (d0_instr !== 32'hFFFF_FFFF || d0_instr_pc4 !== 32'h4) begin
        tests_failed++; $display("FAIL stall_data[%0d]: got instr %h pc4 %h expected ffffffff 00000004", i, d0_instr, d0_instr_pc4);
      end
      tick();
    end
    tests_run++;
    if (dut0.buf_count !== 2'd2) begin tests_failed++; $display("FAIL stall_count: got %0d expected 2", dut0.buf_count); end
    tests_run++;
    if (d0_req_log.size() != 2) begin tests_failed++; $display("FAIL stall_requests: got %0d expected 2", d0_req_log.size()); end
    instr_ready = 1'b1;
    repeat (10) tick();
    exp_q = '{32'h0, 32'h4, 32'h8};
    tests_run++;
    if (got_pc_q.size() < 3) begin
      tests_failed++; $display("FAIL stall_drain_count: got %0d expected at least 3", got_pc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_pc_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL stall_drain_pc[%0d]: got %h expected %h", i, got_pc_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_redirect_drop();
    int n;
    int idx;
    instr_ready = 1'b1;
    mem_lat     = 3;
    do_reset();
    n = 0;
    while (!(d0_req_log.size() > 0 && d0_req_log[$] == 32'h8) && n < 60) begin
      tick();
      n++;
    end
    tests_run++;
    if (n >= 60) begin
      tests_failed++; $display("FAIL drop_wait_req8: got no request for 00000008 within 60 cycles expected one");
      return;
    end
    tick();
    tests_run++;
    if (d0_state !== ST_WAIT) begin tests_failed++; $display("FAIL drop_pre_state: got %0d expected %0d", d0_state, ST_WAIT); end
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    got_pc_q.delete();
    got_instr_q.delete();
    got_pc4_q.delete();
    tests_run++;
    if (d0_state !== ST_DROP || d0_imem_req !== 1'b0 || d0_instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL drop_state: got state %0d req %0b valid %0b expected state %0d req 0 valid 0", d0_state, d0_imem_req, d0_instr_valid, ST_DROP);
    end
    idx = d0_req_log.size();
    n = 0;
    while (d0_req_log.size() <= idx && n < 20) begin tick(); n++; end
    tests_run++;
    if (d0_req_log.size() <= idx) begin
      tests_failed++; $display("FAIL drop_next_addr: got no new request expected 00000100");
    end else if (d0_req_log[idx] !== 32'h100) begin
      tests_failed++; $display("FAIL drop_next_addr: got %h expected 00000100", d0_req_log[idx]);
    end
    n = 0;
    while (got_pc_q.size() == 0 && n < 20) begin tick(); n++; end
    tests_run++;
    if (got_pc_q.size() == 0) begin
      tests_failed++; $display("FAIL drop_next_instr: got no instruction expected pc 00000100");
    end else if (got_pc_q[0] !== 32'h100 || got_instr_q[0] !== 32'hFFFF_FEFF) begin
      tests_failed++; $display("FAIL drop_next_instr: got pc %h instr %h expected pc 00000100 instr fffffeff", got_pc_q[0], got_instr_q[0]);
    end
  endtask

  task automatic test_redirect_rvalid();
    int n;
    instr_ready = 1'b0;
    mem_lat     = 1;
    do_reset();
    n = 0;
    while (!(d0_imem_rvalid && d0_instr_valid && d0_state == ST_WAIT) && n < 30) begin
      tick();
      n++;
    end
    tests_run++;
    if (n >= 30) begin
      tests_failed++; $display("FAIL coinc_setup: got no rvalid with a buffered head within 30 cycles expected one");
      return;
    end
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    got_pc_q.delete();
    got_instr_q.delete();
    got_pc4_q.delete();
    tests_run++;
    if (d0_instr_valid !== 1'b0) begin tests_failed++; $display("FAIL coinc_flush: got valid %0b expected 0", d0_instr_valid); end
    tests_run++;
    if (dut0.buf_count !== 2'd0) begin tests_failed++; $display("FAIL coinc_count: got %0d expected 0", dut0.buf_count); end
    tests_run++;
    if (d0_state !== ST_FETCH || d0_imem_req !== 1'b1 || d0_imem_addr !== 32'h200) begin
      tests_failed++; $display("FAIL coinc_refetch: got state %0d req %0b addr %h expected state %0d req 1 addr 00000200", d0_state, d0_imem_req, d0_imem_addr, ST_FETCH);
    end
    n = 1;
    while (!d0_instr_valid && n < 20) begin tick(); n++; end
    tests_run++;
    if (n != 3) begin tests_failed++; $display("FAIL coinc_latency: got %0d cycles expected 3", n); end
    tick();
    tests_run++;
    if (got_pc_q.size() == 0) begin
      tests_failed++; $display("FAIL coinc_first_pc: got no instruction expected pc 00000200");
    end else if (got_pc_q[0] !== 32'h200 || got_instr_q[0] !== 32'hFFFF_FDFF) begin
      tests_failed++; $display("FAIL coinc_first_pc: got pc %h instr %h expected pc 00000200 instr fffffdff", got_pc_q[0], got_instr_q[0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    instr_ready = 1'b1;
    mem_lat     = 3;
    do_reset();
    n = 0;
    while (d0_state != ST_WAIT && n < 20) begin tick(); n++; end
    tests_run++;
    if (n >= 20) begin tests_failed++; $display("FAIL midrst_setup: got state %0d expected %0d", d0_state, ST_WAIT); end
    mem_en = 1'b0;
    rst    = 1'b1;
    #1;
    tests_run++;
    if (d0_state !== ST_IDLE || d0_imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_async: got state %0d req %0b expected state %0d req 0", d0_state, d0_imem_req, ST_IDLE);
    end
    d0_imem_rvalid = 1'b1;
    d0_imem_rdata  = 32'hDEAD_BEEF;
    tick();
    tick();
    clear_logs();
    rst = 1'b0;
    mem_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (d0_instr_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_valid[%0d]: got %0b expected 0", i, d0_instr_valid); end
      tick();
    end
    tests_run++;
    if (d0_req_log.size() == 0) begin
      tests_failed++; $display("FAIL midrst_first_addr: got no request expected 00000000");
    end else if (d0_req_log[0] !== RESET_PC_DEFAULT) begin
      tests_failed++; $display("FAIL midrst_first_addr: got %h expected %h", d0_req_log[0], RESET_PC_DEFAULT);
    end
    n = 0;
    while (got_pc_q.size() == 0 && n < 20) begin tick(); n++; end
    tests_run++;
    if (got_pc_q.size() == 0) begin
      tests_failed++; $display("FAIL midrst_first_instr: got no instruction expected pc 0");
    end else if (got_pc_q[0] !== 32'h0 || got_instr_q[0] !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL midrst_first_instr: got pc %h instr %h expected pc 00000000 instr ffffffff", got_pc_q[0], got_instr_q[0]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w[3];
    exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    instr_ready = 1'b1;
    do_reset();
    repeat (20) tick();
    tests_run++;
    if (d1_req_log.size() < 3 || w_pc_q.size() < 3) begin
      tests_failed++; $display("FAIL wrap_count: got %0d requests %0d instrs expected at least 3 each", d1_req_log.size(), w_pc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (d1_req_log[i] !== exp_w[i]) begin tests_failed++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, d1_req_log[i], exp_w[i]); end
        tests_run++;
        if (w_pc_q[i] !== exp_w[i]) begin tests_failed++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, w_pc_q[i], exp_w[i]); end
      end
      tests_run++;
      if (w_pc4_q[0] !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc4_0: got %h expected fffffffc", w_pc4_q[0]); end
      tests_run++;
      if (w_pc4_q[1] !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_pc4_1: got %h expected 00000000", w_pc4_q[1]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    #1;
    rst = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_rvalid();
    test_reset_mid_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
